// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, extracts and extends load data,
// and hands {pc, dest, final_result, gr_we} to WB while exporting bypass/load-use info to ID.
module mem_stage #(
    parameter int TO_MEM_W = 75,
    parameter int TO_WB_W  = 70
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TO_MEM_W-1:0] to_MEM_data,
    input  logic                EX_to_MEM_valid,
    output logic                MEM_allow_in,
    output logic [TO_WB_W-1:0]  to_WB_data,
    output logic                MEM_to_WB_valid,
    input  logic                WB_allow_in,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    output logic                MEM_fwd_valid,
    output logic [4:0]          MEM_fwd_dest,
    output logic [31:0]         MEM_fwd_data,
    output logic                MEM_load_pending
);

    logic                mem_valid;
    logic [TO_MEM_W-1:0] bundle;
    logic                resp_buf_valid;
    logic [31:0]         resp_buf;

    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        gr_we;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_op;

    assign {pc, dest, alu_result, gr_we, is_load, is_store, mem_op} = bundle;

    logic mem_req;
    logic mem_ready_go;
    logic leave;
    logic buf_capture;

    assign mem_req         = is_load | is_store;
    assign mem_ready_go    = !mem_req | data_sram_data_ok | resp_buf_valid;
    assign MEM_allow_in    = !mem_valid | (mem_ready_go & WB_allow_in);
    assign MEM_to_WB_valid = mem_valid & mem_ready_go;
    assign leave           = MEM_to_WB_valid & WB_allow_in;
    // Responses are only captured when WB stalls; stray data_ok pulses fall through this guard.
    assign buf_capture     = data_sram_data_ok & mem_valid & mem_req & !resp_buf_valid & !WB_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
            bundle    <= '0;
        end else begin
            if (MEM_allow_in)
                mem_valid <= EX_to_MEM_valid;
            if (EX_to_MEM_valid && MEM_allow_in)
                bundle <= to_MEM_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_buf_valid <= 1'b0;
            resp_buf       <= '0;
        end else if (leave) begin
            resp_buf_valid <= 1'b0;
            resp_buf       <= '0;
        end else if (buf_capture) begin
            resp_buf_valid <= 1'b1;
            resp_buf       <= data_sram_rdata;
        end
    end

    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] final_result;

    assign load_word = resp_buf_valid ? resp_buf : data_sram_rdata;

    always_comb begin
        load_byte = load_word[7:0];
        case (alu_result[1:0])
            2'd0: load_byte = load_word[7:0];
            2'd1: load_byte = load_word[15:8];
            2'd2: load_byte = load_word[23:16];
            2'd3: load_byte = load_word[31:24];
            default: load_byte = load_word[7:0];
        endcase
    end

    // Halfword select ignores off[0]; misaligned halfwords are not trapped here.
    assign load_half = alu_result[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        load_ext = load_word;
        case (mem_op)
            3'b001:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b011:  load_ext = {24'd0, load_byte};
            3'b010:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {16'd0, load_half};
            default: load_ext = load_word;
        endcase
    end

    assign final_result = is_load ? load_ext : alu_result;

    assign to_WB_data       = {pc, dest, final_result, gr_we};
    assign MEM_fwd_valid    = mem_valid & gr_we & (dest != 5'd0);
    assign MEM_fwd_dest     = dest;
    assign MEM_fwd_data     = final_result;
    assign MEM_load_pending = mem_valid & is_load & !mem_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected WB bundles are queued when stimulus is driven and
// compared when the stage hands an instruction to WB.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [74:0] to_MEM_data;
    logic        EX_to_MEM_valid;
    logic        MEM_allow_in;
    logic [69:0] to_WB_data;
    logic        MEM_to_WB_valid;
    logic        WB_allow_in;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        MEM_fwd_valid;
    logic [4:0]  MEM_fwd_dest;
    logic [31:0] MEM_fwd_data;
    logic        MEM_load_pending;

    int n_tests = 0;
    int n_fail  = 0;
    logic [69:0] sb[$];

    mem_stage #(.TO_MEM_W(75), .TO_WB_W(70)) dut (
        .clk               (clk),
        .reset             (reset),
        .to_MEM_data       (to_MEM_data),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .MEM_allow_in      (MEM_allow_in),
        .to_WB_data        (to_WB_data),
        .MEM_to_WB_valid   (MEM_to_WB_valid),
        .WB_allow_in       (WB_allow_in),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .MEM_fwd_valid     (MEM_fwd_valid),
        .MEM_fwd_dest      (MEM_fwd_dest),
        .MEM_fwd_data      (MEM_fwd_data),
        .MEM_load_pending  (MEM_load_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [74:0] mk_ex(input logic [31:0] pc, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic we, input logic ld,
                                          input logic st, input logic [2:0] op);
        return {pc, dest, alu, we, ld, st, op};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic [4:0] dest,
                                          input logic [31:0] res, input logic we);
        return {pc, dest, res, we};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (op)
            3'b001:  return b[7]  ? (b | 32'hFFFFFF00) : b;
            3'b011:  return b;
            3'b010:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b100:  return h;
            default: return w;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every hand-off to WB must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && MEM_to_WB_valid && WB_allow_in) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed %h expected no output", to_WB_data);
            end
            if (sb.size() != 0) chk("sb_out", to_WB_data, sb.pop_front());
        end
    end

    // Issue one load/store, answer it after 'delay' stall cycles, WB always ready.
    task automatic mem_run(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] alu,
                           input logic ld, input logic [2:0] op, input logic [31:0] rdata,
                           input logic [31:0] exp_res, input int delay);
        to_MEM_data     = mk_ex(pc, dest, alu, ld, ld, !ld, op);
        EX_to_MEM_valid = 1'b1;
        sb.push_back(mk_wb(pc, dest, exp_res, ld));
        tick();
        EX_to_MEM_valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            #2;
            chk("stall_pending", MEM_load_pending, ld);
            chk("stall_wb_valid", MEM_to_WB_valid, 1'b0);
            chk("stall_allow_in", MEM_allow_in, 1'b0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        #2;
        chk("resp_wb_valid", MEM_to_WB_valid, 1'b1);
        chk("resp_fwd_data", MEM_fwd_data, exp_res);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        to_MEM_data = '0;
        EX_to_MEM_valid = 1'b0;
        WB_allow_in = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        tick();
        tick();
        #2;
        chk("rst_wb_valid", MEM_to_WB_valid, 1'b0);
        chk("rst_allow_in", MEM_allow_in, 1'b1);
        chk("rst_wb_data", to_WB_data, 70'd0);
        chk("rst_fwd", {MEM_fwd_valid, MEM_fwd_dest, MEM_fwd_data, MEM_load_pending}, 70'd0);
        reset = 1'b0;
        tick();

        // Plain ALU op: one cycle through, forwarded.
        to_MEM_data     = mk_ex(32'h1C000000, 5'd5, 32'h11, 1'b1, 1'b0, 1'b0, 3'b000);
        EX_to_MEM_valid = 1'b1;
        sb.push_back(mk_wb(32'h1C000000, 5'd5, 32'h11, 1'b1));
        tick();
        EX_to_MEM_valid = 1'b0;
        #2;
        chk("add_wb_valid", MEM_to_WB_valid, 1'b1);
        chk("add_fwd_valid", MEM_fwd_valid, 1'b1);
        chk("add_fwd_dest", MEM_fwd_dest, 5'd5);
        chk("add_fwd_data", MEM_fwd_data, 32'h11);
        tick();
        #2;
        chk("idle_wb_valid", MEM_to_WB_valid, 1'b0);
        tick();

        // Byte/half/word extraction with same-cycle responses.
        mem_run(32'h1C000010, 5'd6, 32'h00000101, 1'b1, 3'b001, 32'h123480FF, 32'hFFFFFF80, 0);
        mem_run(32'h1C000014, 5'd6, 32'h00000101, 1'b1, 3'b011, 32'h123480FF, 32'h00000080, 0);
        mem_run(32'h1C000018, 5'd7, 32'h00000202, 1'b1, 3'b010, 32'h8234FFFF, 32'hFFFF8234, 0);
        mem_run(32'h1C00001C, 5'd7, 32'h00000202, 1'b1, 3'b100, 32'h8234FFFF, 32'h00008234, 0);
        mem_run(32'h1C000020, 5'd7, 32'h00000202, 1'b1, 3'b000, 32'h8234FFFF, 32'h8234FFFF, 0);
        // Store: result is the address, no register write, never forwarded.
        mem_run(32'h1C000024, 5'd0, 32'h00003000, 1'b0, 3'b000, 32'h0BADF00D, 32'h00003000, 1);

        // Load stalled 3 cycles; a new instruction enters on the leave cycle.
        to_MEM_data     = mk_ex(32'h1C000100, 5'd7, 32'h1000, 1'b1, 1'b1, 1'b0, 3'b000);
        EX_to_MEM_valid = 1'b1;
        sb.push_back(mk_wb(32'h1C000100, 5'd7, 32'hCAFEF00D, 1'b1));
        tick();
        EX_to_MEM_valid = 1'b0;
        repeat (3) begin
            #2;
            chk("ld3_pending", MEM_load_pending, 1'b1);
            chk("ld3_allow_in", MEM_allow_in, 1'b0);
            chk("ld3_wb_valid", MEM_to_WB_valid, 1'b0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFEF00D;
        to_MEM_data       = mk_ex(32'h1C000104, 5'd8, 32'h22, 1'b1, 1'b0, 1'b0, 3'b000);
        EX_to_MEM_valid   = 1'b1;
        sb.push_back(mk_wb(32'h1C000104, 5'd8, 32'h22, 1'b1));
        #2;
        chk("ld3_leave_allow", MEM_allow_in, 1'b1);
        chk("ld3_leave_pend", MEM_load_pending, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        EX_to_MEM_valid   = 1'b0;
        #2;
        chk("next_wb_valid", MEM_to_WB_valid, 1'b1);
        chk("next_fwd_data", MEM_fwd_data, 32'h22);
        tick();

        // Response arrives while WB stalls: buffered, then delivered 2 cycles later.
        WB_allow_in     = 1'b0;
        to_MEM_data     = mk_ex(32'h1C000200, 5'd9, 32'h2000, 1'b1, 1'b1, 1'b0, 3'b000);
        EX_to_MEM_valid = 1'b1;
        sb.push_back(mk_wb(32'h1C000200, 5'd9, 32'hDEADBEEF, 1'b1));
        tick();
        EX_to_MEM_valid   = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h12345678;
        #2;
        chk("buf_wb_valid", MEM_to_WB_valid, 1'b1);
        chk("buf_data", MEM_fwd_data, 32'hDEADBEEF);
        chk("buf_allow_in", MEM_allow_in, 1'b0);
        tick();
        WB_allow_in = 1'b1;
        #2;
        chk("buf_release", MEM_fwd_data, 32'hDEADBEEF);
        tick();

        // Stray responses (idle stage, non-memory op) must not fill the buffer.
        WB_allow_in       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0BAD0;
        tick();
        data_sram_data_ok = 1'b0;
        to_MEM_data       = mk_ex(32'h1C000300, 5'd3, 32'h33, 1'b1, 1'b0, 1'b0, 3'b000);
        EX_to_MEM_valid   = 1'b1;
        sb.push_back(mk_wb(32'h1C000300, 5'd3, 32'h33, 1'b1));
        tick();
        EX_to_MEM_valid   = 1'b0;
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        WB_allow_in       = 1'b1;
        tick();
        to_MEM_data       = mk_ex(32'h1C000304, 5'd4, 32'h44, 1'b1, 1'b1, 1'b0, 3'b000);
        EX_to_MEM_valid   = 1'b1;
        sb.push_back(mk_wb(32'h1C000304, 5'd4, 32'h600DF00D, 1'b1));
        tick();
        EX_to_MEM_valid = 1'b0;
        #2;
        chk("stray_pending", MEM_load_pending, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h600DF00D;
        tick();
        data_sram_data_ok = 1'b0;

        // Reset with a buffered response clears everything.
        WB_allow_in     = 1'b0;
        to_MEM_data     = mk_ex(32'h1C000400, 5'd10, 32'h3000, 1'b1, 1'b1, 1'b0, 3'b000);
        EX_to_MEM_valid = 1'b1;
        tick();
        EX_to_MEM_valid   = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55555555;
        tick();
        data_sram_data_ok = 1'b0;
        reset = 1'b1;
        tick();
        #2;
        chk("rst2_wb_valid", MEM_to_WB_valid, 1'b0);
        chk("rst2_allow_in", MEM_allow_in, 1'b1);
        chk("rst2_wb_data", to_WB_data, 70'd0);
        chk("rst2_pending", MEM_load_pending, 1'b0);
        reset       = 1'b0;
        WB_allow_in = 1'b1;
        tick();
        mem_run(32'h1C000500, 5'd11, 32'h4000, 1'b1, 3'b000, 32'h0F0F0F0F, 32'h0F0F0F0F, 1);

        // Randomised loads against the reference extractor.
        for (int k = 0; k < 10; k++) begin
            logic [31:0] a;
            logic [31:0] w;
            logic [2:0]  op;
            a  = $urandom;
            w  = $urandom;
            op = 3'($urandom_range(0, 5));
            mem_run(32'h1C001000 + 32'(k * 4), 5'(k + 1), a, 1'b1, op, w, ref_load(op, a[1:0], w),
                    int'($urandom_range(0, 2)));
        end

        tick();
        chk("sb_drained", 70'(sb.size()), 70'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
